ahb_slave_mem: RTL and testbench
================================

Name: ahb_slave_mem

Overview:
- AHB-Lite responder (slave end) for word-wide register/memory accesses, driven by the team's AHB master model.
- Accepts pipelined address phases and performs word writes and reads into an internal array.
- Inserts a programmable number of wait states per transfer.
- Returns the two-cycle ERROR response for addresses outside its window.
- Acts as the bus-side endpoint for exercising master transfers ahead of the APB bridge path.

Parameters:
BASE_ADDR, 32'h8000_0000, window base; must be aligned to 4*2^ADDR_W bytes
ADDR_W, 4, log2 of word count (16 words, 64-byte window)
WAIT_STATES, 0, wait cycles inserted per OKAY transfer, legal range 0..7

Ports:
HCLK  input  1  clock, all state on rising edge
HRESET  input  1  asynchronous, active-high reset
HTRANS  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
HADDR  input  32  byte address, sampled in address phase
HWRITE  input  1  1 write / 0 read, sampled in address phase
HREADYin  input  1  bus ready; address phase accepted only when high
HWDATA  input  32  write data, valid during data phase
HRDATA  output  32  read data, valid in read data phase when HREADY_OUT=1
HRESP  output  2  00 OKAY, 01 ERROR
HREADY_OUT  output  1  0 extends current data phase

Behaviour:
- Reset (async, active-high):
  - HREADY_OUT=1, HRESP=00, HRDATA=0.
  - All array words cleared to 0.
  - FSM in IDLE, wait counter 0.
  - Reset asserted mid-transfer aborts it; a pending write is not committed.
- Address-phase acceptance: on a rising edge with HREADYin=1, HREADY_OUT=1 and HTRANS[1]=1.
  - Latch HWRITE and word index = HADDR[ADDR_W+1:2]; HADDR[1:0] is ignored, so 0x8000_0001 maps to word 0.
  - Latch an in-window flag = (HADDR[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).
- IDLE/BUSY, or HREADYin=0: no transfer; next cycle is zero-wait OKAY with no side effects.
- FSM states:
  - IDLE: no active data phase; HREADY_OUT=1, HRESP=00.
    - Accepted in-window transfer with WAIT_STATES=0 -> DATA.
    - Accepted in-window transfer with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
    - Accepted out-of-window transfer -> ERR1.
  - WAIT: HREADY_OUT=0, HRESP=00, counter decrements each cycle; at 0 -> DATA.
  - DATA: HREADY_OUT=1, HRESP=00.
    - Write: HWDATA stored to array[index] on the edge ending this cycle.
    - Read: HRDATA=array[index], combinational in this cycle.
    - A new acceptance in the same cycle chains to WAIT/DATA/ERR1 as from IDLE; otherwise -> IDLE.
  - ERR1: HREADY_OUT=0, HRESP=01 -> ERR2.
  - ERR2: HREADY_OUT=1, HRESP=01; no array access. A new acceptance chains as from IDLE, else -> IDLE.
- Total latency per transfer: an OKAY data phase lasts WAIT_STATES+1 cycles; an ERROR data phase lasts exactly 2 cycles.
- HRDATA: 0 in every cycle that is not a read DATA cycle.
- Back-to-back write then read of the same word: the write commits on the edge that starts the read data phase, so the read returns the new value (no stale read).
- SEQ is treated as NONSEQ: each beat carries its own address; no burst address generation.
- During WAIT and ERR1, HREADY_OUT=0, so no new address phase is accepted regardless of HTRANS.

Test Plan:
- Reset: assert HRESET mid-idle -> HREADY_OUT=1, HRESP=00, HRDATA=0; read of 0x8000_0000 returns 0x0000_0000.
- WAIT_STATES=0: NONSEQ write 0x8000_0001 with HWDATA 0x0000_1122, then NONSEQ read 0x8000_0001 -> HREADY_OUT never low, HRESP=00, HRDATA=0x0000_1122 in the read data phase.
- WAIT_STATES=2: write 0x8000_0008 = 0xDEAD_BEEF -> HREADY_OUT low exactly 2 cycles then high. Following read -> HRDATA=0xDEAD_BEEF after 2 wait cycles.
- Out-of-window: write 0x9000_0000 = 0x5555_5555 -> HRESP=01 for 2 cycles, HREADY_OUT 0 then 1. Read of 0x8000_0000 is still the prior value.
- Pipelined: write 0x8000_000C = 0xA5A5_A5A5 immediately followed by read 0x8000_000C (NONSEQ consecutive) -> read data phase HRDATA=0xA5A5_A5A5. An interleaved HTRANS=0 or 1 cycle -> OKAY, no write.
- Reset during a WAIT cycle of a write to 0x8000_0004 -> HREADY_OUT=1 immediately. Subsequent read of 0x8000_0004 returns 0x0000_0000.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-access memory responder with programmable wait states and a
// two-cycle ERROR response for addresses outside its window.
module ahb_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic        HREADYin,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        HREADY_OUT
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          cnt;
  logic [2:0]          cnt_nxt;
  logic                wr_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         mem [DEPTH];
  logic                accept;
  logic                in_win;

  // Byte-lane bits and the SEQ/NONSEQ distinction play no part in decoding.
  logic unused_bits;
  assign unused_bits = ^{HADDR[1:0], HTRANS[0]};

  assign in_win = (HADDR[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    HREADY_OUT = 1'b1;
    HRESP      = 2'b00;
    HRDATA     = '0;
    accept     = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_IDLE;
      S_WAIT: begin
        HREADY_OUT = 1'b0;
        if (cnt == 3'd0) state_nxt = S_DATA;
        else             cnt_nxt   = cnt - 3'd1;
      end
      S_DATA: begin
        if (!wr_q) HRDATA = mem[idx_q];
        state_nxt = S_IDLE;
      end
      S_ERR1: begin
        HREADY_OUT = 1'b0;
        HRESP      = 2'b01;
        state_nxt  = S_ERR2;
      end
      S_ERR2: begin
        HRESP     = 2'b01;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Acceptance is only possible while HREADY_OUT is high (IDLE, DATA, ERR2),
    // so it overrides the default return to IDLE chosen above.
    accept = HREADYin && HREADY_OUT && HTRANS[1];
    if (accept) begin
      if (!in_win) begin
        state_nxt = S_ERR1;
      end else if (WAIT_STATES == 0) begin
        state_nxt = S_DATA;
      end else begin
        state_nxt = S_WAIT;
        cnt_nxt   = WAIT_LOAD;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= S_IDLE;
      cnt   <= '0;
      wr_q  <= 1'b0;
      idx_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_DATA && wr_q) mem[idx_q] <= HWDATA;
      if (accept) begin
        wr_q  <= HWRITE;
        idx_q <= HADDR[ADDR_W+1:2];
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three instances with 0, 2 and 7 wait states,
// a vector table of single transfers plus hand-written pipelined/reset sequences.
module tb_ahb_slave_mem;

  logic        clk = 1'b0;
  logic [2:0]  rst;
  logic [1:0]  htrans [3];
  logic [31:0] haddr  [3];
  logic [2:0]  hwrite;
  logic [2:0]  hreadyin;
  logic [2:0]  block;
  logic [31:0] hwdata [3];
  logic [31:0] hrdata [3];
  logic [1:0]  hresp  [3];
  logic [2:0]  hready_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign hreadyin = hready_out & ~block;

  ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .ADDR_W(4), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESET(rst[0]), .HTRANS(htrans[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HREADYin(hreadyin[0]), .HWDATA(hwdata[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0]),
    .HREADY_OUT(hready_out[0]));

  ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .ADDR_W(4), .WAIT_STATES(2)) u_ws2 (
    .HCLK(clk), .HRESET(rst[1]), .HTRANS(htrans[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HREADYin(hreadyin[1]), .HWDATA(hwdata[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1]),
    .HREADY_OUT(hready_out[1]));

  ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .ADDR_W(4), .WAIT_STATES(7)) u_ws7 (
    .HCLK(clk), .HRESET(rst[2]), .HTRANS(htrans[2]), .HADDR(haddr[2]), .HWRITE(hwrite[2]),
    .HREADYin(hreadyin[2]), .HWDATA(hwdata[2]), .HRDATA(hrdata[2]), .HRESP(hresp[2]),
    .HREADY_OUT(hready_out[2]));

  typedef struct {
    int          d;
    logic [1:0]  tr;
    logic [31:0] a;
    logic        w;
    logic [31:0] wd;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          exp_waits;
  } vec_t;

  vec_t vt [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One non-pipelined transfer; returns data/response seen in its data phase.
  task automatic xfer(input int d, input logic [1:0] tr, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] rsp_first,
                      output logic [1:0] rsp_last, output int waits);
    @(posedge clk); #1;
    htrans[d] = tr; haddr[d] = a; hwrite[d] = w;
    @(posedge clk); #1;
    htrans[d] = 2'b00; hwdata[d] = wd;
    waits = 0;
    @(negedge clk);
    rsp_first = hresp[d];
    while (hready_out[d] == 1'b0 && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    rsp_last = hresp[d];
    rd = hrdata[d];
  endtask

  task automatic do_read(input int d, input logic [31:0] a, input logic [31:0] exp_data,
                         input int exp_waits, input string tag);
    logic [31:0] rd;
    logic [1:0]  r0, r1;
    int          wt;
    xfer(d, 2'b10, a, 1'b0, 32'h0, rd, r0, r1, wt);
    check({tag, " rdata"}, rd, exp_data);
    check({tag, " resp"}, {30'b0, r1}, 32'h0);
    check({tag, " waits"}, wt, exp_waits);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  r0, r1;
    int          wt;

    rst = 3'b111; block = '0; hwrite = '0;
    for (int i = 0; i < 3; i++) begin
      htrans[i] = 2'b00; haddr[i] = '0; hwdata[i] = '0;
    end

    vt.push_back('{0, 2'd2, 32'h8000_0000, 1'b0, 32'h0,         32'h0,         2'b00, 0});
    vt.push_back('{0, 2'd2, 32'h8000_0001, 1'b1, 32'h0000_1122, 32'h0,         2'b00, 0});
    vt.push_back('{0, 2'd2, 32'h8000_0001, 1'b0, 32'h0,         32'h0000_1122, 2'b00, 0});
    vt.push_back('{0, 2'd2, 32'h9000_0000, 1'b1, 32'h5555_5555, 32'h0,         2'b01, 1});
    vt.push_back('{0, 2'd2, 32'h8000_0000, 1'b0, 32'h0,         32'h0000_1122, 2'b00, 0});
    vt.push_back('{0, 2'd2, 32'h9000_0000, 1'b0, 32'h0,         32'h0,         2'b01, 1});
    vt.push_back('{0, 2'd3, 32'h8000_003C, 1'b1, 32'h0F0F_0000, 32'h0,         2'b00, 0});
    vt.push_back('{0, 2'd3, 32'h8000_003E, 1'b0, 32'h0,         32'h0F0F_0000, 2'b00, 0});
    vt.push_back('{0, 2'd2, 32'h8000_0040, 1'b0, 32'h0,         32'h0,         2'b01, 1});
    vt.push_back('{0, 2'd2, 32'h7FFF_FFFC, 1'b0, 32'h0,         32'h0,         2'b01, 1});
    vt.push_back('{0, 2'd1, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 32'h0,         2'b00, 0});
    vt.push_back('{0, 2'd0, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 32'h0,         2'b00, 0});
    vt.push_back('{0, 2'd2, 32'h8000_0000, 1'b0, 32'h0,         32'h0000_1122, 2'b00, 0});
    vt.push_back('{1, 2'd2, 32'h8000_0008, 1'b1, 32'hDEAD_BEEF, 32'h0,         2'b00, 2});
    vt.push_back('{1, 2'd2, 32'h8000_0008, 1'b0, 32'h0,         32'hDEAD_BEEF, 2'b00, 2});
    vt.push_back('{1, 2'd2, 32'hA000_0008, 1'b1, 32'h1234_0000, 32'h0,         2'b01, 1});
    vt.push_back('{1, 2'd2, 32'h8000_0008, 1'b0, 32'h0,         32'hDEAD_BEEF, 2'b00, 2});
    vt.push_back('{2, 2'd2, 32'h8000_0014, 1'b1, 32'h1234_5678, 32'h0,         2'b00, 7});
    vt.push_back('{2, 2'd2, 32'h8000_0014, 1'b0, 32'h0,         32'h1234_5678, 2'b00, 7});
    vt.push_back('{2, 2'd2, 32'h8000_0010, 1'b0, 32'h0,         32'h0,         2'b00, 7});
    vt.push_back('{2, 2'd2, 32'hC000_0000, 1'b0, 32'h0,         32'h0,         2'b01, 1});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d hready", i), {31'b0, hready_out[i]}, 32'h1);
      check($sformatf("rst%0d hresp", i), {30'b0, hresp[i]}, 32'h0);
      check($sformatf("rst%0d hrdata", i), hrdata[i], 32'h0);
    end
    @(posedge clk); #1;
    rst = 3'b000;

    // Vector table
    for (int i = 0; i < vt.size(); i++) begin
      xfer(vt[i].d, vt[i].tr, vt[i].a, vt[i].w, vt[i].wd, rd, r0, r1, wt);
      check($sformatf("v%0d rdata", i), rd, vt[i].exp_data);
      check($sformatf("v%0d resp_first", i), {30'b0, r0}, {30'b0, vt[i].exp_resp});
      check($sformatf("v%0d resp_last", i), {30'b0, r1}, {30'b0, vt[i].exp_resp});
      check($sformatf("v%0d waits", i), wt, vt[i].exp_waits);
    end

    // Back-to-back write then read of the same word (no stale read)
    @(posedge clk); #1;
    htrans[0] = 2'b10; haddr[0] = 32'h8000_000C; hwrite[0] = 1'b1;
    @(posedge clk); #1;
    htrans[0] = 2'b10; haddr[0] = 32'h8000_000C; hwrite[0] = 1'b0; hwdata[0] = 32'hA5A5_A5A5;
    @(negedge clk);
    check("pipe wr hready", {31'b0, hready_out[0]}, 32'h1);
    check("pipe wr hrdata", hrdata[0], 32'h0);
    @(posedge clk); #1;
    htrans[0] = 2'b00;
    @(negedge clk);
    check("pipe rd hrdata", hrdata[0], 32'hA5A5_A5A5);
    check("pipe rd hresp", {30'b0, hresp[0]}, 32'h0);

    // ERROR response with a read held until accepted in ERR2
    @(posedge clk); #1;
    htrans[0] = 2'b10; haddr[0] = 32'h9000_0000; hwrite[0] = 1'b1;
    @(posedge clk); #1;
    haddr[0] = 32'h8000_000C; hwrite[0] = 1'b0; hwdata[0] = 32'h5555_5555;
    @(negedge clk);
    check("err1 hready", {31'b0, hready_out[0]}, 32'h0);
    check("err1 hresp", {30'b0, hresp[0]}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("err2 hready", {31'b0, hready_out[0]}, 32'h1);
    check("err2 hresp", {30'b0, hresp[0]}, 32'h1);
    check("err2 hrdata", hrdata[0], 32'h0);
    @(posedge clk); #1;
    htrans[0] = 2'b00;
    @(negedge clk);
    check("err chain rdata", hrdata[0], 32'hA5A5_A5A5);
    check("err chain hresp", {30'b0, hresp[0]}, 32'h0);

    // Interleaved BUSY/IDLE and HREADYin low must not cause extra writes
    @(posedge clk); #1;
    htrans[0] = 2'b10; haddr[0] = 32'h8000_000C; hwrite[0] = 1'b1;
    @(posedge clk); #1;
    htrans[0] = 2'b01; hwdata[0] = 32'h1111_1111;
    @(negedge clk);
    check("busy hready", {31'b0, hready_out[0]}, 32'h1);
    @(posedge clk); #1;
    htrans[0] = 2'b00; hwdata[0] = 32'h2222_2222;
    @(negedge clk);
    check("idle hresp", {30'b0, hresp[0]}, 32'h0);
    @(posedge clk); #1;
    block[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1;
    @(posedge clk); #1;
    block[0] = 1'b0; htrans[0] = 2'b00; hwdata[0] = 32'h3333_3333;
    @(negedge clk);
    check("blocked hready", {31'b0, hready_out[0]}, 32'h1);
    do_read(0, 32'h8000_000C, 32'h1111_1111, 0, "no extra write");

    // Reset in the middle of a waited write aborts it and clears the array
    @(posedge clk); #1;
    htrans[1] = 2'b10; haddr[1] = 32'h8000_0004; hwrite[1] = 1'b1;
    @(posedge clk); #1;
    htrans[1] = 2'b00; hwdata[1] = 32'hCAFE_F00D;
    @(negedge clk);
    check("wait hready", {31'b0, hready_out[1]}, 32'h0);
    #1 rst[1] = 1'b1;
    #1;
    check("async rst hready", {31'b0, hready_out[1]}, 32'h1);
    check("async rst hresp", {30'b0, hresp[1]}, 32'h0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    do_read(1, 32'h8000_0004, 32'h0, 2, "aborted write");
    do_read(1, 32'h8000_0008, 32'h0, 2, "cleared word");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
